mux_scan_controller: RTL and testbench

MUX_SCAN_CONTROLLER -- requirements
Module: mux_scan_controller

---
 rtl/mux_scan_controller.sv | 141 ++++++++++++++
 tb/tb_mux_scan_controller.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_controller.sv
// mux_scan_controller
//   Walks the select of a downstream 4:1 mux through channels 0..3. It holds
//   each select stable for SETTLE cycles and then samples the returned bit.
//   After channel 3 it publishes the assembled nibble on data, with a
//   one-cycle done pulse. It either stops there or, in continuous mode,
//   starts the next scan at once.
module mux_scan_controller #(
    parameter int SETTLE = 2  // settle cycles per channel, legal 1..15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       continuous,
    input  logic       stop,
    input  logic       y,
    output logic [1:0] c,
    output logic       busy,
    output logic [3:0] data,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_PUBLISH
    } state_t;

    // Counter value on the last settle cycle of a channel.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state;
    state_t     state_n;
    logic [3:0] cnt;
    logic [3:0] cnt_n;
    logic       mode;
    logic       mode_n;
    logic [3:0] shadow;
    logic [3:0] shadow_n;
    logic [1:0] c_n;
    logic [3:0] data_n;
    logic       done_n;
    logic       busy_n;

    // Next-state and next-output logic for every registered signal.
    always_comb begin
        // NOTE: every signal gets a default first, so no path can leave one
        // unassigned and infer a latch.
        state_n  = state;
        cnt_n    = cnt;
        mode_n   = mode;
        shadow_n = shadow;
        c_n      = c;
        data_n   = data;
        done_n   = 1'b0;

        // While a scan is running, stop drops continuous mode. The scan in
        // flight still completes and publishes.
        if (state != ST_IDLE && stop) begin
            mode_n = 1'b0;
        end

        unique case (state)
            ST_IDLE: begin
                c_n = 2'd0;
                if (start) begin
                    state_n = ST_SETTLE;
                    cnt_n   = 4'd0;
                    mode_n  = continuous & ~stop;
                end
            end

            ST_SETTLE: begin
                // Legal SETTLE (<= 15) keeps cnt at or below 15, so it never wraps.
                cnt_n = cnt + 4'd1;
                if (cnt == SETTLE_LAST) begin
                    state_n = ST_SAMPLE;
                end
            end

            ST_SAMPLE: begin
                shadow_n[c] = y;
                if (c != 2'd3) begin
                    c_n     = c + 2'd1;
                    cnt_n   = 4'd0;
                    state_n = ST_SETTLE;
                end else begin
                    state_n = ST_PUBLISH;
                end
            end

            ST_PUBLISH: begin
                data_n = shadow;
                done_n = 1'b1;
                c_n    = 2'd0;
                cnt_n  = 4'd0;
                // A stop arriving in this very cycle also ends the run.
                if (mode && !stop) begin
                    state_n = ST_SETTLE;
                end else begin
                    state_n = ST_IDLE;
                end
            end

            default: begin
                state_n = ST_IDLE;
                c_n     = 2'd0;
            end
        endcase

        busy_n = (state_n != ST_IDLE);
    end

    // State register and registered outputs; synchronous reset wins over all.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // register samples the values from before the edge.
        if (reset) begin
            // NOTE: shadow is a plain 4-bit register, not a memory. It is
            // reset so that an aborted scan can never leak partial data.
            state  <= ST_IDLE;
            cnt    <= 4'd0;
            mode   <= 1'b0;
            shadow <= 4'd0;
            c      <= 2'd0;
            data   <= 4'd0;
            done   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            mode   <= mode_n;
            shadow <= shadow_n;
            c      <= c_n;
            data   <= data_n;
            done   <= done_n;
            busy   <= busy_n;
        end
    end

endmodule

// File: tb/tb_mux_scan_controller.sv
// tb_mux_scan_controller
//   Bench for mux_scan_controller with two instances: SETTLE = 2 and
//   SETTLE = 1. Each instance drives a modelled 4:1 mux. Expected
//   {data, done edge} pairs are queued when a scan starts and are popped
//   when done is seen.
module tb_mux_scan_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start;
    logic       continuous;
    logic       stop;
    logic [3:0] x;
    logic       y;
    logic [1:0] c;
    logic       busy;
    logic [3:0] data;
    logic       done;

    logic       start1;
    logic [3:0] x1;
    logic       y1;
    logic [1:0] c1;
    logic       busy1;
    logic [3:0] data1;
    logic       done1;

    // Downstream 4:1 muxes.
    assign y  = x[c];
    assign y1 = x1[c1];

    mux_scan_controller #(.SETTLE(2)) dut (
        .clk(clk), .reset(reset), .start(start), .continuous(continuous),
        .stop(stop), .y(y), .c(c), .busy(busy), .data(data), .done(done)
    );

    mux_scan_controller #(.SETTLE(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .continuous(1'b0),
        .stop(1'b0), .y(y1), .c(c1), .busy(busy1), .data(data1), .done(done1)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
    endtask

    typedef struct {
        logic [3:0] d;
        int         at;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    // Scoreboard for the SETTLE = 2 instance.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (q0.size() == 0) begin
                check("unexpected_done", done, 0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                check("done_data", data, e.d);
                check("done_edge", cyc, e.at);
            end
        end
    end

    // Scoreboard for the SETTLE = 1 instance.
    always @(negedge clk) begin
        if (done1 === 1'b1) begin
            if (q1.size() == 0) begin
                check("unexpected_done1", done1, 0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("done1_data", data1, e.d);
                check("done1_edge", cyc, e.at);
            end
        end
    end

    // Single scan on the SETTLE = 2 instance, checking the select trajectory.
    // With repulse set, start is raised again at scan cycles 3 and 7.
    task automatic scan0(input logic [3:0] pat, input bit repulse);
        int acc;
        x = pat; continuous = 1'b0; start = 1'b1;
        acc = cyc + 1;
        q0.push_back('{pat, acc + 13});
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 13; k++) begin
            check("scan_c", c, (k < 12) ? k / 3 : 3);
            check("scan_busy", busy, 1);
            start = repulse && (k == 3 || k == 7);
            @(negedge clk);
        end
        start = 1'b0;
        check("end_busy", busy, 0);
        check("end_c", c, 0);
    endtask

    // Single scan on the SETTLE = 1 instance: 2 cycles per channel.
    task automatic scan1(input logic [3:0] pat);
        int acc;
        x1 = pat; start1 = 1'b1;
        acc = cyc + 1;
        q1.push_back('{pat, acc + 9});
        @(negedge clk);
        start1 = 1'b0;
        for (int k = 0; k < 9; k++) begin
            check("scan1_c", c1, (k < 8) ? k / 2 : 3);
            check("scan1_busy", busy1, 1);
            @(negedge clk);
        end
        check("end1_busy", busy1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc;
        int waited;
        reset = 1'b1; start = 1'b0; continuous = 1'b0; stop = 1'b0;
        x = 4'd0; start1 = 1'b0; x1 = 4'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state.
        check("rst_c", c, 0);
        check("rst_busy", busy, 0);
        check("rst_data", data, 0);
        check("rst_done", done, 0);
        check("rst_data1", data1, 0);

        // Stop in IDLE has no effect.
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("idle_stop_busy", busy, 0);

        // Single scan.
        scan0(4'b1010, 1'b0);
        check("hold_data", data, 4'b1010);

        // Start pulses while busy are ignored.
        scan0(4'b0011, 1'b1);

        // Continuous mode: pattern changes during scan 2, then stop ends the run.
        x = 4'b0110; continuous = 1'b1; start = 1'b1;
        acc = cyc + 1;
        q0.push_back('{4'b0110, acc + 13});
        q0.push_back('{4'b1001, acc + 26});
        @(negedge clk);
        start = 1'b0; continuous = 1'b0;
        repeat (13) @(negedge clk);
        check("cont_busy", busy, 1);
        x = 4'b1001;
        repeat (7) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        repeat (5) @(negedge clk);
        check("cont_end_busy", busy, 0);
        repeat (5) @(negedge clk);
        check("cont_data_hold", data, 4'b1001);

        // Continuous mode, stop while c == 1: exactly one done, then IDLE.
        x = 4'b1100; continuous = 1'b1; start = 1'b1;
        acc = cyc + 1;
        q0.push_back('{4'b1100, acc + 13});
        @(negedge clk);
        start = 1'b0; continuous = 1'b0;
        waited = 0;
        while (c !== 2'd1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("stop_at_c1", c, 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        while (cyc < acc + 14) @(negedge clk);
        check("stop_idle", busy, 0);
        repeat (30) @(negedge clk);
        check("stop_quiet_busy", busy, 0);

        // Reset in the middle of a scan, after data = 1111.
        scan0(4'b1111, 1'b0);
        x = 4'b0101; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (c !== 2'd2 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("rst_at_c2", c, 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_data", data, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_c", c, 0);
        check("mid_rst_done", done, 0);
        repeat (20) @(negedge clk);
        check("mid_rst_quiet", busy, 0);
        scan0(4'b0101, 1'b0);

        // SETTLE = 1 instance.
        scan1(4'b0110);
        scan1(4'b1011);

        repeat (3) @(negedge clk);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
